ann_frame_loader: RTL and testbench
===================================

// Module: ann_frame_loader
// PURPOSE
//  Host-side driver for ANNfull, the fully-connected classifier. Accepts a frame
//  of float32 features as a valid/ready word stream and packs it into the flat
//  input_ANN bus. Sequences ANNfull's reset and run window, then captures the
//  4-bit class into a valid/ready result port. It sits between the feature source
//  (the conv/pool stage or a host DMA) and ANNfull.
// PARAMETERS
//  DATA_WIDTH      32   width of one feature word (IEEE-754 single)
//  NUM_WORDS       288  features per frame (= ANNfull INPUT_NODES_L1)
//  RESET_HOLD      10   cycles ann_reset stays high with a stable, complete frame
//  COMPUTE_CYCLES  700  cycles ANNfull runs out of reset before its output is sampled
//  CLASS_WIDTH     4    width of the class index
// PORTS
//  clk           in   1                     clock, rising edge
//  reset         in   1                     asynchronous, active-high
//  s_data        in   DATA_WIDTH            feature word
//  s_valid       in   1                     s_data valid
//  s_last        in   1                     marks final word of frame
//  s_ready       out  1                     loader accepts a word
//  frame_err     out  1                     1-cycle pulse: s_last misplaced, frame dropped
//  ann_input     out  DATA_WIDTH*NUM_WORDS  packed frame to ANNfull input_ANN
//  ann_reset     out  1                     drives ANNfull reset
//  ann_output    in   CLASS_WIDTH           ANNfull output_ANN
//  result_class  out  CLASS_WIDTH           captured class
//  result_valid  out  1                     result_class valid
//  result_ready  in   1                     consumer takes result
//  busy          out  1                     high in HOLD, COMPUTE and DONE
// BEHAVIOUR
//  Reset values: state=LOAD, word count=0, ann_input=0, ann_reset=1, result_class=0,
//   result_valid=0, frame_err=0, busy=0.
//  States: LOAD -> HOLD -> COMPUTE -> DONE -> LOAD.
//  s_ready = (state==LOAD). ann_reset = (state!=COMPUTE). busy = (state!=LOAD).
//  LOAD: handshake = s_valid&s_ready. Word k goes to
//   ann_input[DATA_WIDTH*(NUM_WORDS-k)-1 -: DATA_WIDTH]. Word 0 is the MSB slice.
//   - Handshake at k<NUM_WORDS-1 with s_last=1: frame_err pulses next cycle,
//     count->0, stay LOAD. Stale slices stay in place until overwritten.
//   - Handshake at k=NUM_WORDS-1 with s_last=0: same error handling.
//   - Handshake at k=NUM_WORDS-1 with s_last=1: count->0, state->HOLD.
//  HOLD: ann_input is frozen. After exactly RESET_HOLD cycles in HOLD -> COMPUTE.
//  COMPUTE: ann_reset=0 for exactly COMPUTE_CYCLES cycles. On the clock edge ending
//   the last cycle, register ann_output into result_class, set result_valid=1,
//   state->DONE.
//  DONE: result_class and result_valid hold until result_valid&result_ready;
//   then result_valid->0, state->LOAD.
//  Latency: last word accepted at edge T -> ann_reset falls at T+RESET_HOLD,
//   result_valid rises at T+RESET_HOLD+COMPUTE_CYCLES.
//  ann_input changes only on LOAD handshakes. It is never cleared except by reset.
//  Async reset mid-operation: every register returns to its reset value at once,
//   ann_reset=1 and the partial frame is lost.
//  Counters are sized $clog2 of their maximum value. No wrap occurs: each counter
//   reloads on state entry.
// STRUCTURE
//  Shared header ann_defs.vh: state encodings (LOAD=0, HOLD=1, COMPUTE=2, DONE=3)
//   and default DATA_WIDTH, NUM_WORDS and CLASS_WIDTH, shared with ANNfull and its bench.
//  Sub-module ann_cycle_timer: loadable down-counter with a done flag. One instance
//   is loaded with RESET_HOLD-1 on HOLD entry and COMPUTE_CYCLES-1 on COMPUTE entry.
// TESTING (NUM_WORDS=4, RESET_HOLD=2, COMPUTE_CYCLES=5 unless noted)
//  1 Send 32'h11111111..32'h44444444, s_last on 4th word -> ann_input=
//    128'h11111111222222223333333344444444; ann_reset low exactly 5 cycles;
//    result_valid 7 cycles after last handshake.
//  2 ann_output=4'd7 during COMPUTE, result_ready=0 for 10 cycles -> result_class=7
//    held and s_ready=0 throughout. result_ready=1 -> result_valid falls, s_ready=1.
//  3 s_last on word 2 -> frame_err 1-cycle pulse, state stays LOAD. Next 4-word
//    frame loads correctly.
//  4 No s_last on word 4 -> frame_err pulse, no HOLD entry, ann_reset stays 1.
//  5 Assert reset during COMPUTE -> ann_reset=1 and result_valid=0 asynchronously,
//    ann_input=0, s_ready=1.
//  6 Defaults with the 288-word bench frame, s_valid toggled randomly -> class
//    matches the direct ANNfull run, and no word is accepted while busy.

Source files
------------

// File: rtl/ann_frame_loader_pkg.sv
// Shared definitions for the ANNfull host-side frame loader: state encodings,
// default geometry and small elaboration-time helpers.
package ann_frame_loader_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } ann_state_e;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_NUM_WORDS      = 288;
  localparam int DEF_CLASS_WIDTH    = 4;
  localparam int DEF_RESET_HOLD     = 10;
  localparam int DEF_COMPUTE_CYCLES = 700;

  // Bit width able to hold values 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ann_cycle_timer.sv
// Loadable down-counter: a load takes priority, otherwise it counts down while
// enabled and parks at zero, where done is raised.
module ann_cycle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/ann_frame_loader.sv
// Packs a valid/ready stream of float32 features into ANNfull's flat input bus,
// sequences ANNfull's reset/run window and returns the class on a valid/ready port.
module ann_frame_loader
  import ann_frame_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_WORDS      = DEF_NUM_WORDS,
  parameter int RESET_HOLD     = DEF_RESET_HOLD,
  parameter int COMPUTE_CYCLES = DEF_COMPUTE_CYCLES,
  parameter int CLASS_WIDTH    = DEF_CLASS_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           s_data,
  input  logic                            s_valid,
  input  logic                            s_last,
  output logic                            s_ready,
  output logic                            frame_err,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] ann_input,
  output logic                            ann_reset,
  input  logic [CLASS_WIDTH-1:0]          ann_output,
  output logic [CLASS_WIDTH-1:0]          result_class,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic                            busy
);

  localparam int CNT_W = clog2_min1(NUM_WORDS);
  localparam int TMR_W = clog2_min1(max_int(RESET_HOLD, COMPUTE_CYCLES));
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_WORDS - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(RESET_HOLD - 1);
  localparam logic [TMR_W-1:0] RUN_LOAD  = TMR_W'(COMPUTE_CYCLES - 1);

  ann_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CLASS_WIDTH-1:0] class_q, class_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic                   hs;
  logic                   tmr_load;
  logic                   tmr_en;
  logic                   tmr_done;
  logic [TMR_W-1:0]       tmr_value;

  assign hs = s_valid && (state_q == ST_LOAD);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    class_d   = class_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = HOLD_LOAD;
    tmr_en    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (hs) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
            if (s_last) begin
              state_d   = ST_HOLD;
              tmr_load  = 1'b1;
              tmr_value = HOLD_LOAD;
            end else begin
              err_d = 1'b1;
            end
          end else if (s_last) begin
            // Early end-of-frame: restart counting, older slices are left as is.
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          state_d   = ST_COMPUTE;
          tmr_load  = 1'b1;
          tmr_value = RUN_LOAD;
        end
      end
      ST_COMPUTE: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          state_d = ST_DONE;
          class_d = ann_output;
          valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      class_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      class_q <= class_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Word k lands in slice NUM_WORDS-1-k so word 0 occupies the MSBs.
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_slice
    logic [DATA_WIDTH-1:0] word_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_q <= '0;
      end else if (hs && (cnt_q == CNT_W'(gi))) begin
        word_q <= s_data;
      end
    end

    assign ann_input[DATA_WIDTH*(NUM_WORDS-gi)-1 -: DATA_WIDTH] = word_q;
  end

  ann_cycle_timer #(
    .WIDTH(TMR_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_value(tmr_value),
    .en        (tmr_en),
    .done      (tmr_done)
  );

  assign s_ready      = (state_q == ST_LOAD);
  assign busy         = (state_q != ST_LOAD);
  assign ann_reset    = (state_q != ST_COMPUTE);
  assign frame_err    = err_q;
  assign result_class = class_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_ann_frame_loader.sv
// Directed bench for ann_frame_loader: a small 4-word instance for the protocol
// scenarios and a default-sized instance driven by a nibble-fold ANNfull stand-in.
module tb_ann_frame_loader;

  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int NW  = 4;
  localparam int RH  = 2;
  localparam int CC  = 5;
  localparam int FNW = 288;
  localparam int FRH = 10;
  localparam int FCC = 700;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [DW-1:0]    s_data;
  logic             s_valid, s_last, s_ready, frame_err;
  logic [DW*NW-1:0] ann_input;
  logic             ann_reset;
  logic [CW-1:0]    ann_output, result_class;
  logic             result_valid, result_ready, busy;

  logic [DW-1:0]     f_s_data;
  logic              f_s_valid, f_s_last, f_s_ready, f_frame_err;
  logic [DW*FNW-1:0] f_ann_input;
  logic              f_ann_reset;
  logic [CW-1:0]     f_ann_output, f_result_class;
  logic              f_result_valid, f_result_ready, f_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  ann_frame_loader #(
    .DATA_WIDTH(DW), .NUM_WORDS(NW), .RESET_HOLD(RH),
    .COMPUTE_CYCLES(CC), .CLASS_WIDTH(CW)
  ) u_dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .frame_err(frame_err), .ann_input(ann_input),
    .ann_reset(ann_reset), .ann_output(ann_output), .result_class(result_class),
    .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
  );

  ann_frame_loader u_dut_full (
    .clk(clk), .reset(reset), .s_data(f_s_data), .s_valid(f_s_valid), .s_last(f_s_last),
    .s_ready(f_s_ready), .frame_err(f_frame_err), .ann_input(f_ann_input),
    .ann_reset(f_ann_reset), .ann_output(f_ann_output), .result_class(f_result_class),
    .result_valid(f_result_valid), .result_ready(f_result_ready), .busy(f_busy)
  );

  // Stand-in classifier: XOR of every nibble of the frame, only while out of reset.
  function automatic logic [CW-1:0] fold_nibbles(input logic [DW*FNW-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < DW*FNW/4; i++) r ^= v[i*4 +: 4];
    return r;
  endfunction

  always_comb f_ann_output = f_ann_reset ? '0 : fold_nibbles(f_ann_input);

  task automatic send_word(input logic [DW-1:0] d, input logic last);
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_result(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (result_valid) seen = 1'b1;
    end
  endtask

  task automatic drain;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({s_ready, ann_reset, busy, result_valid, frame_err} !== 5'b11000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 11000", {s_ready, ann_reset, busy, result_valid, frame_err});
    end
    tests_run++;
    if (ann_input !== '0 || result_class !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got input=%h class=%h expected 0", ann_input, result_class);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({s_ready, ann_reset, busy} !== 3'b110) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got %b expected 110", {s_ready, ann_reset, busy});
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic_frame;
    int first_low, low_cnt, rise;
    ann_output = 4'd3;
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    send_word(32'h33333333, 1'b0);
    send_word(32'h44444444, 1'b1);
    tests_run++;
    if (ann_input !== 128'h11111111222222223333333344444444) begin
      tests_failed++;
      $display("FAIL basic_pack: got %h expected 11111111222222223333333344444444", ann_input);
    end
    tests_run++;
    if ({busy, s_ready, ann_reset} !== 3'b101) begin
      tests_failed++;
      $display("FAIL basic_hold_entry: got %b expected 101", {busy, s_ready, ann_reset});
    end
    first_low = 0; low_cnt = 0; rise = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (!ann_reset) begin
        low_cnt++;
        if (first_low == 0) first_low = i;
      end
      if (result_valid && rise == 0) rise = i;
    end
    tests_run++;
    if (first_low !== RH) begin
      tests_failed++;
      $display("FAIL basic_reset_fall: got %0d expected %0d", first_low, RH);
    end
    tests_run++;
    if (low_cnt !== CC) begin
      tests_failed++;
      $display("FAIL basic_reset_low_len: got %0d expected %0d", low_cnt, CC);
    end
    tests_run++;
    if (rise !== RH + CC) begin
      tests_failed++;
      $display("FAIL basic_result_latency: got %0d expected %0d", rise, RH + CC);
    end
    tests_run++;
    if (result_class !== 4'd3) begin
      tests_failed++;
      $display("FAIL basic_class: got %0d expected 3", result_class);
    end
    drain();
    $display("[TB] test_basic_frame done: class=%0d latency=%0d", result_class, rise);
  endtask

  task automatic test_result_hold;
    bit seen;
    int bad;
    ann_output = 4'd7;
    send_word(32'hA0000001, 1'b0);
    send_word(32'hA0000002, 1'b0);
    send_word(32'hA0000003, 1'b0);
    send_word(32'hA0000004, 1'b1);
    wait_result(seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL hold_result_timeout: got result_valid=0 expected 1");
    end
    ann_output = 4'd9;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (result_class !== 4'd7 || !result_valid || s_ready) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL hold_stable: got %0d bad cycles expected 0 (class=%0d)", bad, result_class);
    end
    drain();
    tests_run++;
    if ({result_valid, s_ready, busy} !== 3'b010) begin
      tests_failed++;
      $display("FAIL hold_release: got %b expected 010", {result_valid, s_ready, busy});
    end
    $display("[TB] test_result_hold done");
  endtask

  task automatic test_early_last;
    bit seen;
    send_word(32'hBBBB0001, 1'b0);
    send_word(32'hBBBB0002, 1'b1);
    tests_run++;
    if ({frame_err, s_ready, busy} !== 3'b110) begin
      tests_failed++;
      $display("FAIL early_err_pulse: got %b expected 110", {frame_err, s_ready, busy});
    end
    @(posedge clk); #1;
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_err_width: got %b expected 0", frame_err);
    end
    send_word(32'h01020304, 1'b0);
    send_word(32'h05060708, 1'b0);
    send_word(32'h090A0B0C, 1'b0);
    send_word(32'h0D0E0F10, 1'b1);
    tests_run++;
    if (ann_input !== 128'h01020304_05060708_090A0B0C_0D0E0F10 || !busy) begin
      tests_failed++;
      $display("FAIL early_reload: got %h busy=%b expected 0102030405060708090a0b0c0d0e0f10 busy=1", ann_input, busy);
    end
    wait_result(seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL early_result_timeout: got result_valid=0 expected 1");
    end
    drain();
    $display("[TB] test_early_last done");
  endtask

  task automatic test_missing_last;
    bit seen;
    int bad;
    send_word(32'hCCCC0001, 1'b0);
    send_word(32'hCCCC0002, 1'b0);
    send_word(32'hCCCC0003, 1'b0);
    send_word(32'hCCCC0004, 1'b0);
    tests_run++;
    if ({frame_err, busy, ann_reset} !== 3'b101) begin
      tests_failed++;
      $display("FAIL missing_err: got %b expected 101", {frame_err, busy, ann_reset});
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (!ann_reset || busy || frame_err) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL missing_no_hold: got %0d bad cycles expected 0", bad);
    end
    send_word(32'hD0000001, 1'b0);
    send_word(32'hD0000002, 1'b0);
    send_word(32'hD0000003, 1'b0);
    send_word(32'hD0000004, 1'b1);
    tests_run++;
    if (ann_input !== 128'hD0000001_D0000002_D0000003_D0000004 || !busy) begin
      tests_failed++;
      $display("FAIL missing_reload: got %h busy=%b expected d0000001d0000002d0000003d0000004 busy=1", ann_input, busy);
    end
    wait_result(seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL missing_result_timeout: got result_valid=0 expected 1");
    end
    drain();
    $display("[TB] test_missing_last done");
  endtask

  task automatic test_async_reset;
    bit in_compute;
    send_word(32'hE0000001, 1'b0);
    send_word(32'hE0000002, 1'b0);
    send_word(32'hE0000003, 1'b0);
    send_word(32'hE0000004, 1'b1);
    in_compute = 1'b0;
    for (int i = 0; i < 10 && !in_compute; i++) begin
      @(posedge clk); #1;
      if (!ann_reset) in_compute = 1'b1;
    end
    tests_run++;
    if (!in_compute) begin
      tests_failed++;
      $display("FAIL async_compute_timeout: got ann_reset=1 expected 0");
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({ann_reset, result_valid, s_ready, busy} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL async_flags: got %b expected 1010", {ann_reset, result_valid, s_ready, busy});
    end
    tests_run++;
    if (ann_input !== '0) begin
      tests_failed++;
      $display("FAIL async_input_clear: got %h expected 0", ann_input);
    end
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({ann_reset, s_ready, busy} !== 3'b110) begin
      tests_failed++;
      $display("FAIL async_after_release: got %b expected 110", {ann_reset, s_ready, busy});
    end
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_default_frame;
    logic [DW-1:0]     words [FNW];
    logic [DW*FNW-1:0] exp_vec;
    logic [CW-1:0]     exp_class;
    logic [DW-1:0]     w;
    int idx, cyc, lat, leak;
    bit v, rdy;
    exp_vec   = '0;
    exp_class = '0;
    for (int k = 0; k < FNW; k++) begin
      w        = $urandom;
      words[k] = w;
      exp_vec[DW*(FNW-k)-1 -: DW] = w;
      for (int n = 0; n < DW/4; n++) exp_class ^= w[n*4 +: 4];
    end
    idx = 0;
    cyc = 0;
    while (idx < FNW && cyc < 2000) begin
      v         = 1'($urandom_range(0, 1));
      f_s_valid = v;
      f_s_data  = words[idx];
      f_s_last  = (idx == FNW - 1);
      rdy       = f_s_ready;
      @(posedge clk); #1;
      cyc++;
      if (v && rdy) idx++;
    end
    tests_run++;
    if (idx !== FNW) begin
      tests_failed++;
      $display("FAIL full_accept_count: got %0d expected %0d", idx, FNW);
    end
    f_s_valid = 1'b1;
    f_s_data  = 32'hDEADBEEF;
    f_s_last  = 1'b1;
    lat  = 0;
    leak = 0;
    while (!f_result_valid && lat < 800) begin
      @(posedge clk); #1;
      lat++;
      if (f_s_ready) leak++;
    end
    f_s_valid = 1'b0;
    f_s_last  = 1'b0;
    tests_run++;
    if (lat !== FRH + FCC) begin
      tests_failed++;
      $display("FAIL full_latency: got %0d expected %0d", lat, FRH + FCC);
    end
    tests_run++;
    if (leak !== 0) begin
      tests_failed++;
      $display("FAIL full_ready_while_busy: got %0d cycles expected 0", leak);
    end
    tests_run++;
    if (f_ann_input !== exp_vec) begin
      tests_failed++;
      $display("FAIL full_pack: got top word %h expected %h", f_ann_input[DW*FNW-1 -: DW], words[0]);
    end
    tests_run++;
    if (f_result_class !== exp_class) begin
      tests_failed++;
      $display("FAIL full_class: got %0d expected %0d", f_result_class, exp_class);
    end
    f_result_ready = 1'b1;
    @(posedge clk); #1;
    f_result_ready = 1'b0;
    tests_run++;
    if ({f_result_valid, f_s_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL full_release: got %b expected 01", {f_result_valid, f_s_ready});
    end
    $display("[TB] test_default_frame done: class=%0d latency=%0d", f_result_class, lat);
  endtask

  initial begin
    reset          = 1'b1;
    s_data         = '0;
    s_valid        = 1'b0;
    s_last         = 1'b0;
    ann_output     = '0;
    result_ready   = 1'b0;
    f_s_data       = '0;
    f_s_valid      = 1'b0;
    f_s_last       = 1'b0;
    f_result_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_result_hold();
    test_early_last();
    test_missing_last();
    test_async_reset();
    test_default_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
